kmeans_update_ctrl: RTL and testbench

KMEANS_UPDATE_CTRL -- requirements
Module: kmeans_update_ctrl

---
 rtl/kmeans_update_ctrl.sv | 172 +++++++++++++++++
 tb/tb_kmeans_update_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_update_ctrl.sv
// K-means centroid update: divides per-cluster coordinate sums by member counts
// using one shared restoring divider, time-multiplexed over eight jobs.
module kmeans_update_ctrl #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*ACC_W-1:0]   accu_x,
  input  logic [4*ACC_W-1:0]   accu_y,
  input  logic [4*CNT_W-1:0]   num,
  input  logic [63:0]          cur_cent,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          new_cent,
  output logic                 converged
);

  localparam int unsigned BC_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam int unsigned OFS_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state;
  logic [2:0]           job;
  logic [4*ACC_W-1:0]   snap_x;
  logic [4*ACC_W-1:0]   snap_y;
  logic [4*CNT_W-1:0]   snap_num;
  logic [63:0]          snap_cent;
  logic [63:0]          work;
  logic [CNT_W-1:0]     rem;
  logic [ACC_W-1:0]     quo;
  logic [CNT_W-1:0]     divisor;
  logic [BC_W-1:0]      bit_cnt;

  logic [1:0]           cl;
  logic [CNT_W-1:0]     cur_num;
  logic [ACC_W-1:0]     cur_sum;
  logic [OFS_W-1:0]     ofs;
  logic [7:0]           cur_coord;
  logic [CNT_W:0]       trial;
  logic [CNT_W:0]       diff;
  logic                 ge;
  logic [CNT_W-1:0]     rem_nxt;
  logic [ACC_W-1:0]     quo_nxt;
  logic [7:0]           sat_q;
  logic [63:0]          work_upd;
  logic                 last_job;

  // Job decode: cluster j>>1, x when j even (byte 1), y when j odd (byte 0)
  always_comb begin
    cl        = job[2:1];
    cur_num   = snap_num[cl*CNT_W +: CNT_W];
    cur_sum   = job[0] ? snap_y[cl*ACC_W +: ACC_W] : snap_x[cl*ACC_W +: ACC_W];
    ofs       = {cl, ~job[0], 3'b000};
    cur_coord = snap_cent[ofs +: 8];
    last_job  = (job == 3'd7);
  end

  // One restoring-division step: quotient bits shift in where dividend bits leave
  always_comb begin
    trial   = {rem, quo[ACC_W-1]};
    diff    = trial - {1'b0, divisor};
    ge      = (trial >= {1'b0, divisor});
    rem_nxt = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_nxt = {quo[ACC_W-2:0], ge};
  end

  // Working result with the current job's byte merged, so DONE sees the final write
  always_comb begin
    sat_q    = (quo > ACC_W'(255)) ? 8'hFF : quo[7:0];
    work_upd = work;
    if (state == LOAD) begin
      work_upd[ofs +: 8] = cur_coord;
    end else begin
      work_upd[ofs +: 8] = sat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      job       <= 3'd0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_num  <= '0;
      snap_cent <= '0;
      work      <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      new_cent  <= '0;
      converged <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_x    <= accu_x;
            snap_y    <= accu_y;
            snap_num  <= num;
            snap_cent <= cur_cent;
            job       <= 3'd0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (cur_num == '0) begin
            // Empty cluster keeps its old coordinate
            work <= work_upd;
            if (last_job) begin
              new_cent  <= work_upd;
              converged <= (work_upd == snap_cent);
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              job   <= job + 3'd1;
              state <= LOAD;
            end
          end else begin
            rem     <= '0;
            quo     <= cur_sum;
            divisor <= cur_num;
            bit_cnt <= BC_W'(ACC_W - 1);
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (bit_cnt == '0) begin
            state <= STORE;
          end else begin
            bit_cnt <= bit_cnt - BC_W'(1);
          end
        end
        STORE: begin
          work <= work_upd;
          if (last_job) begin
            new_cent  <= work_upd;
            converged <= (work_upd == snap_cent);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            job   <= job + 3'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_update_ctrl.sv
// Directed bench for kmeans_update_ctrl: vector table of centroid updates plus
// hand sequences for restart-while-busy, start around DONE and mid-run reset.
module tb_kmeans_update_ctrl;

  localparam int unsigned ACC_W = 20;
  localparam int unsigned CNT_W = 12;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [4*ACC_W-1:0] accu_x;
  logic [4*ACC_W-1:0] accu_y;
  logic [4*CNT_W-1:0] num;
  logic [63:0]        cur_cent;
  logic               busy;
  logic               done;
  logic [63:0]        new_cent;
  logic               converged;

  kmeans_update_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .accu_x    (accu_x),
    .accu_y    (accu_y),
    .num       (num),
    .cur_cent  (cur_cent),
    .busy      (busy),
    .done      (done),
    .new_cent  (new_cent),
    .converged (converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*ACC_W-1:0] ax;
    logic [4*ACC_W-1:0] ay;
    logic [4*CNT_W-1:0] nm;
    logic [63:0]        cc;
    logic [63:0]        exp_nc;
    logic               exp_cv;
    int                 exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   n_pass;
  int   n_total;
  bit   busy_drop;

  function automatic logic [4*ACC_W-1:0] pa(int unsigned a0, int unsigned a1,
                                            int unsigned a2, int unsigned a3);
    return {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
  endfunction

  function automatic logic [4*CNT_W-1:0] pn(int unsigned n0, int unsigned n1,
                                            int unsigned n2, int unsigned n3);
    return {CNT_W'(n3), CNT_W'(n2), CNT_W'(n1), CNT_W'(n0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Counts edges after the start-sampling edge until done is seen; -1 on timeout
  task automatic wait_done(input int max_cyc, input int restart_at, output int lat);
    lat = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_drop = 1'b1;
      start = (c == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    accu_x   = v.ax;
    accu_y   = v.ay;
    num      = v.nm;
    cur_cent = v.cc;
  endtask

  task automatic scramble();
    accu_x   = 80'({$urandom(), $urandom(), $urandom()});
    accu_y   = 80'({$urandom(), $urandom(), $urandom()});
    num      = 48'({$urandom(), $urandom()});
    cur_cent = 64'({$urandom(), $urandom()});
  endtask

  // Pulses start at a negedge; returns at the negedge after the sampling edge
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  flag;

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    accu_x  = '0;
    accu_y  = '0;
    num     = '0;
    cur_cent = '0;

    // All clusters count 1: plain copy of sums
    vecs[0] = '{pa(10, 20, 30, 40), pa(11, 21, 31, 41), pn(1, 1, 1, 1), 64'h0,
                64'h2829_1E1F_1415_0A0B, 1'b0, 176};
    // Floor, exact 255 and saturation; two empty clusters keep old coordinates
    vecs[1] = '{pa(100, 5000, 0, 0), pa(767, 7, 0, 0), pn(3, 1, 0, 0),
                64'h5678_1234_0000_0000, 64'h5678_1234_FF07_21FF, 1'b0, 92};
    // Cluster 2 empty, extreme dividend/divisor elsewhere
    vecs[2] = '{pa(9, 1048575, 0, 2559), pa(1000000, 4094, 0, 99),
                pn(2, 4095, 0, 10), 64'h0000_ABCD_0000_0000,
                64'hFF09_ABCD_FF00_04FF, 1'b0, 134};
    // Sums reproduce the current centroids (with sub-count remainders on x)
    vecs[3] = '{pa(118, 342, 566, 790), pa(224, 448, 672, 896), pn(7, 7, 7, 7),
                64'h7080_5060_3040_1020, 64'h7080_5060_3040_1020, 1'b1, 176};
    // No members anywhere: result is the snapshot, fastest latency
    vecs[4] = '{pa(5, 6, 7, 8), pa(9, 10, 11, 12), pn(0, 0, 0, 0),
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 8};
    // Remainders and saturation; snapshot differs only in the last bit
    vecs[5] = '{pa(89, 51254, 0, 767), pa(4, 1048575, 255, 256), pn(5, 255, 1, 3),
                64'hFF55_00FF_C8FF_1101, 64'hFF55_00FF_C8FF_1100, 1'b0, 176};

    // Reset held, then idle with no start
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || done || (new_cent != '0) || converged) flag = 1'b1;
    end
    chk("idle_quiet", 64'(flag), 64'h0);
    chk("idle_new_cent", new_cent, 64'h0);
    chk("idle_converged", 64'(converged), 64'h0);

    // Table-driven runs; inputs scrambled right after the snapshot edge
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      kick();
      scramble();
      chk($sformatf("v%0d_busy_rise", i), 64'(busy), 64'h1);
      busy_drop = 1'b0;
      wait_done(400, (i == 0) ? 30 : 0, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_busy_held", i), 64'(busy_drop), 64'h0);
      chk($sformatf("v%0d_busy_fall", i), 64'(busy), 64'h0);
      chk($sformatf("v%0d_new_cent", i), new_cent, vecs[i].exp_nc);
      chk($sformatf("v%0d_converged", i), 64'(converged), 64'(vecs[i].exp_cv));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
      chk($sformatf("v%0d_hold", i), new_cent, vecs[i].exp_nc);
    end

    // start during DONE is ignored; start in the following IDLE cycle is taken
    @(negedge clk);
    apply(vecs[1]);
    kick();
    wait_done(400, 0, lat);
    chk("dn_latency", 64'(lat), 64'd92);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("dn_start_ignored", 64'(busy), 64'h0);
    apply(vecs[4]);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("dn_start_accepted", 64'(busy), 64'h1);
    wait_done(400, 0, lat);
    chk("dn_relatency", 64'(lat), 64'd8);
    chk("dn_new_cent", new_cent, vecs[4].exp_nc);

    // Extra start at cycle 30, reset at cycle 50 of a long run
    @(negedge clk);
    apply(vecs[0]);
    kick();
    flag = 1'b0;
    for (int c = 1; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) flag = 1'b1;
      start = (c == 30);
    end
    start = 1'b0;
    chk("rr_no_early_done", 64'(flag), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", 64'(busy), 64'h0);
    chk("rr_new_cent", new_cent, 64'h0);
    chk("rr_converged", 64'(converged), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (done || busy || (new_cent != '0)) flag = 1'b1;
    end
    chk("rr_quiet_after", 64'(flag), 64'h0);
    kick();
    wait_done(400, 0, lat);
    chk("rr_fresh_latency", 64'(lat), 64'd176);
    chk("rr_fresh_new_cent", new_cent, vecs[0].exp_nc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
